// File: rtl/alu_system_ctrl_if.sv
// Control/status bundle between the alu_system_ctrl sequencer and the 8-bit ALU datapath.
// master = sequencer (drives controls, observes IR and flags); slave = datapath.
interface alu_system_ctrl_if;
   localparam int unsigned InstrW = 16;
   localparam int unsigned FlagW  = 4;

   logic [InstrW-1:0] IROut;
   logic [FlagW-1:0]  ALUOutFlag;

   logic [2:0] RF_OutASel;
   logic [2:0] RF_OutBSel;
   logic [1:0] RF_FunSel;
   logic [3:0] RF_RSel;
   logic [3:0] RF_TSel;
   logic [3:0] ALU_FunSel;

   logic [1:0] ARF_OutCSel;
   logic [1:0] ARF_OutDSel;
   logic [1:0] ARF_FunSel;
   logic [3:0] ARF_RegSel;

   logic       IR_LH;
   logic       IR_Enable;
   logic [1:0] IR_Funsel;
   logic       Mem_WR;
   logic       Mem_CS;
   logic [1:0] MuxASel;
   logic [1:0] MuxBSel;
   logic       MuxCSel;

   modport master (
      input  IROut, ALUOutFlag,
      output RF_OutASel, RF_OutBSel, RF_FunSel, RF_RSel, RF_TSel, ALU_FunSel,
      output ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
      output IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS, MuxASel, MuxBSel, MuxCSel
   );

   modport slave (
      output IROut, ALUOutFlag,
      input  RF_OutASel, RF_OutBSel, RF_FunSel, RF_RSel, RF_TSel, ALU_FunSel,
      input  ARF_OutCSel, ARF_OutDSel, ARF_FunSel, ARF_RegSel,
      input  IR_LH, IR_Enable, IR_Funsel, Mem_WR, Mem_CS, MuxASel, MuxBSel, MuxCSel
   );
endinterface

// File: rtl/alu_system_ctrl.sv
// Hardwired fetch/execute sequencer for the 8-bit ALU datapath: two-byte fetch, one-cycle execute.
// Optional single-step mode: define ALU_SYSTEM_CTRL_STEP_EN to park in WAIT_STEP after each instruction.
module alu_system_ctrl (
   input  logic              Clock,
   input  logic              Reset_n,
   input  logic              Start,
   input  logic              Step,
   alu_system_ctrl_if.master dp,
   output logic              Busy,
   output logic              Halted
);
   localparam int unsigned OpW       = 4;
   localparam int unsigned RegFieldW = 2;
   localparam int unsigned SelW      = 4;

   localparam logic [OpW-1:0] OP_NOP  = 4'h0;
   localparam logic [OpW-1:0] OP_LDI  = 4'h1;
   localparam logic [OpW-1:0] OP_LD   = 4'h2;
   localparam logic [OpW-1:0] OP_ST   = 4'h3;
   localparam logic [OpW-1:0] OP_ALU  = 4'h4;
   localparam logic [OpW-1:0] OP_LDAR = 4'h5;
   localparam logic [OpW-1:0] OP_BRZ  = 4'h6;
   localparam logic [OpW-1:0] OP_HLT  = 4'hF;

   localparam logic [1:0] FS_CLEAR = 2'b00;
   localparam logic [1:0] FS_LOAD  = 2'b01;
   localparam logic [1:0] FS_INC   = 2'b11;

   localparam logic [SelW-1:0] REG_PC = 4'b0001;
   localparam logic [SelW-1:0] REG_AR = 4'b0010;

   localparam logic [1:0] OUTD_AR    = 2'b00;
   localparam logic [1:0] OUTD_PC    = 2'b10;
   localparam logic [1:0] MUX_ALU    = 2'b00;
   localparam logic [1:0] MUX_MEM    = 2'b01;
   localparam logic [1:0] MUX_IR     = 2'b10;
   localparam logic       MUXC_RF    = 1'b0;
   localparam logic [3:0] ALU_PASS_A = 4'b0000;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      FETCH_L = 3'd1,
      FETCH_H = 3'd2,
      EXEC    = 3'd3,
      HALT    = 3'd4
`ifdef ALU_SYSTEM_CTRL_STEP_EN
      , WAIT_STEP = 3'd5
`endif
   } stateT;

   stateT state;
   stateT nextState;

   logic [OpW-1:0]       op;
   logic [RegFieldW-1:0] rd;
   logic [RegFieldW-1:0] rs1;
   logic [RegFieldW-1:0] rs2;
   logic [3:0]           aluf;
   logic                 zFlag;
   logic                 startGo;

   assign op    = dp.IROut[15:12];
   assign rd    = dp.IROut[11:10];
   assign rs1   = dp.IROut[9:8];
   assign rs2   = dp.IROut[7:6];
   assign aluf  = dp.IROut[3:0];
   assign zFlag = dp.ALUOutFlag[3];

   // Gate Start with reset so nothing is driven while the block is held in reset.
   assign startGo = Start & Reset_n;

   // Immediate bits [5:4] reach the datapath directly; C/N/O are not consulted.
   logic [1:0] unusedIrBits;
   logic [2:0] unusedFlags;
   assign unusedIrBits = dp.IROut[5:4];
   assign unusedFlags  = dp.ALUOutFlag[2:0];

`ifndef ALU_SYSTEM_CTRL_STEP_EN
   logic unusedStep;
   assign unusedStep = Step;
`endif

   function automatic logic [SelW-1:0] oneHot(input logic [RegFieldW-1:0] n);
      return SelW'(4'b0001 << n);
   endfunction

   // State register
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) state <= IDLE;
      else          state <= nextState;
   end

   // Next-state and control decode
   always_comb begin
      nextState      = state;
      Busy           = 1'b0;
      Halted         = 1'b0;
      dp.RF_OutASel  = '0;
      dp.RF_OutBSel  = '0;
      dp.RF_FunSel   = '0;
      dp.RF_RSel     = '0;
      dp.RF_TSel     = '0;
      dp.ALU_FunSel  = '0;
      dp.ARF_OutCSel = '0;
      dp.ARF_OutDSel = '0;
      dp.ARF_FunSel  = '0;
      dp.ARF_RegSel  = '0;
      dp.IR_LH       = 1'b0;
      dp.IR_Enable   = 1'b0;
      dp.IR_Funsel   = '0;
      dp.Mem_WR      = 1'b0;
      dp.Mem_CS      = 1'b0;
      dp.MuxASel     = '0;
      dp.MuxBSel     = '0;
      dp.MuxCSel     = 1'b0;

      case (state)
         IDLE, HALT: begin
            Halted = (state == HALT);
            if (startGo) begin
               dp.ARF_RegSel = REG_PC;
               dp.ARF_FunSel = FS_CLEAR;
               nextState     = FETCH_L;
            end
         end

         FETCH_L, FETCH_H: begin
            Busy           = 1'b1;
            dp.ARF_OutDSel = OUTD_PC;
            dp.Mem_CS      = 1'b1;
            dp.IR_Enable   = 1'b1;
            dp.IR_LH       = (state == FETCH_H);
            dp.IR_Funsel   = FS_LOAD;
            dp.ARF_RegSel  = REG_PC;
            dp.ARF_FunSel  = FS_INC;
            nextState      = (state == FETCH_L) ? FETCH_H : EXEC;
         end

         EXEC: begin
            Busy = 1'b1;
            case (op)
               OP_NOP: ;
               OP_LDI: begin
                  dp.MuxASel   = MUX_IR;
                  dp.RF_RSel   = oneHot(rd);
                  dp.RF_FunSel = FS_LOAD;
               end
               OP_LD: begin
                  dp.ARF_OutDSel = OUTD_AR;
                  dp.Mem_CS      = 1'b1;
                  dp.MuxASel     = MUX_MEM;
                  dp.RF_RSel     = oneHot(rd);
                  dp.RF_FunSel   = FS_LOAD;
               end
               OP_ST: begin
                  dp.RF_OutASel  = {1'b0, rs1};
                  dp.MuxCSel     = MUXC_RF;
                  dp.ALU_FunSel  = ALU_PASS_A;
                  dp.ARF_OutDSel = OUTD_AR;
                  dp.Mem_CS      = 1'b1;
                  dp.Mem_WR      = 1'b1;
               end
               OP_ALU: begin
                  dp.RF_OutASel = {1'b0, rs1};
                  dp.RF_OutBSel = {1'b0, rs2};
                  dp.MuxCSel    = MUXC_RF;
                  dp.ALU_FunSel = aluf;
                  dp.MuxASel    = MUX_ALU;
                  dp.RF_RSel    = oneHot(rd);
                  dp.RF_FunSel  = FS_LOAD;
               end
               OP_LDAR: begin
                  dp.MuxBSel    = MUX_IR;
                  dp.ARF_RegSel = REG_AR;
                  dp.ARF_FunSel = FS_LOAD;
               end
               OP_BRZ: begin
                  // Flags are those the datapath holds from the last ALU op.
                  if (zFlag) begin
                     dp.MuxBSel    = MUX_IR;
                     dp.ARF_RegSel = REG_PC;
                     dp.ARF_FunSel = FS_LOAD;
                  end
               end
               default: ;
            endcase

            if (op == OP_HLT) begin
               nextState = HALT;
            end else begin
`ifdef ALU_SYSTEM_CTRL_STEP_EN
               nextState = WAIT_STEP;
`else
               nextState = FETCH_L;
`endif
            end
         end

`ifdef ALU_SYSTEM_CTRL_STEP_EN
         WAIT_STEP: begin
            Busy = 1'b1;
            if (Step) nextState = FETCH_L;
         end
`endif

         default: nextState = IDLE;
      endcase
   end
endmodule

// File: tb/tb_alu_system_ctrl.sv
// Randomized bench for alu_system_ctrl: a small datapath model reacts to the controls, and an
// instruction-level reference interpreter predicts both the per-cycle controls and the architectural state.
module tb_alu_system_ctrl;
   localparam int K_ZERO  = 0;
   localparam int K_START = 1;
   localparam int K_FL    = 2;
   localparam int K_FH    = 3;
   localparam int K_EX    = 4;
   localparam int NUM_INSTR = 300;

   logic Clock = 1'b0;
   logic Reset_n;
   logic Start;
   logic Step;
   logic Busy;
   logic Halted;

   alu_system_ctrl_if dpIf ();

   alu_system_ctrl dut (
      .Clock  (Clock),
      .Reset_n(Reset_n),
      .Start  (Start),
      .Step   (Step),
      .dp     (dpIf),
      .Busy   (Busy),
      .Halted (Halted)
   );

   always #5 Clock = ~Clock;

   int checks = 0;
   int errors = 0;

   task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] aluFn(input logic [3:0] f, input logic [7:0] a, input logic [7:0] b);
      case (f)
         4'h0:    return a;
         4'h1:    return 8'(a + b);
         4'h2:    return 8'(a - b);
         4'h3:    return a & b;
         4'h4:    return a | b;
         4'h5:    return a ^ b;
         4'h6:    return ~a;
         default: return b;
      endcase
   endfunction

   // ---------------- datapath model driven by the DUT ----------------
   logic [7:0]  progImg [256];
   logic        loadImg;
   logic [7:0]  dpMem [256];
   logic [7:0]  dpPc = 8'h00;
   logic [7:0]  dpAr = 8'h80;
   logic [15:0] dpIr = 16'h0000;
   logic [7:0]  dpRf [4] = '{default: 8'h00};
   logic        dpZ = 1'b0;
   logic [2:0]  cnoJunk;

   logic [7:0] aluA, aluB, aluRes, dpAddr, memRd, muxAVal, muxBVal;
   assign aluA    = dpRf[dpIf.RF_OutASel[1:0]];
   assign aluB    = dpRf[dpIf.RF_OutBSel[1:0]];
   assign aluRes  = aluFn(dpIf.ALU_FunSel, aluA, aluB);
   assign dpAddr  = (dpIf.ARF_OutDSel == 2'b10) ? dpPc : dpAr;
   assign memRd   = dpMem[dpAddr];
   assign muxAVal = (dpIf.MuxASel == 2'b01) ? memRd : (dpIf.MuxASel == 2'b10) ? dpIr[7:0] : aluRes;
   assign muxBVal = (dpIf.MuxBSel == 2'b01) ? memRd : (dpIf.MuxBSel == 2'b10) ? dpIr[7:0] : aluRes;

   assign dpIf.IROut      = dpIr;
   assign dpIf.ALUOutFlag = {dpZ, cnoJunk};

   always @(posedge Clock) begin
      if (loadImg) dpMem <= progImg;
      if (dpIf.ARF_RegSel[0])
         case (dpIf.ARF_FunSel)
            2'b00: dpPc <= 8'h00;
            2'b01: dpPc <= muxBVal;
            2'b11: dpPc <= 8'(dpPc + 8'd1);
            default: ;
         endcase
      if (dpIf.ARF_RegSel[1])
         case (dpIf.ARF_FunSel)
            2'b00: dpAr <= 8'h00;
            2'b01: dpAr <= muxBVal;
            2'b11: dpAr <= 8'(dpAr + 8'd1);
            default: ;
         endcase
      if (dpIf.IR_Enable && dpIf.IR_Funsel == 2'b01) begin
         if (dpIf.IR_LH) dpIr[15:8] <= memRd;
         else            dpIr[7:0]  <= memRd;
      end
      for (int r = 0; r < 4; r++)
         if (dpIf.RF_RSel[r] && dpIf.RF_FunSel == 2'b01) dpRf[r] <= muxAVal;
      if (dpIf.RF_RSel != 4'b0 && dpIf.RF_FunSel == 2'b01 && dpIf.MuxASel == 2'b00)
         dpZ <= (muxAVal == 8'h00);
      if (dpIf.Mem_CS && dpIf.Mem_WR) dpMem[dpAddr] <= aluRes;
   end

   logic [40:0] obsCtrl;
   assign obsCtrl = {dpIf.RF_OutASel, dpIf.RF_OutBSel, dpIf.RF_FunSel, dpIf.RF_RSel, dpIf.RF_TSel,
                     dpIf.ALU_FunSel, dpIf.ARF_OutCSel, dpIf.ARF_OutDSel, dpIf.ARF_FunSel,
                     dpIf.ARF_RegSel, dpIf.IR_LH, dpIf.IR_Enable, dpIf.IR_Funsel, dpIf.Mem_WR,
                     dpIf.Mem_CS, dpIf.MuxASel, dpIf.MuxBSel, dpIf.MuxCSel};

   // ---------------- instruction-level reference ----------------
   logic [7:0] refMem [256];
   logic [7:0] refPc = 8'h00;
   logic [7:0] refAr = 8'h80;
   logic [7:0] refRf [4] = '{default: 8'h00};
   logic       refZ = 1'b0;

   function automatic logic [40:0] expCtrl(input int kind, input logic [15:0] w, input logic z);
      logic [2:0] oa, ob;
      logic [1:0] rfF, od, arfF, irF, ma, mb;
      logic [3:0] rs, aluF, rg;
      logic       lh, ire, wr, cs;
      oa = '0; ob = '0; rfF = '0; od = '0; arfF = '0; irF = '0; ma = '0; mb = '0;
      rs = '0; aluF = '0; rg = '0; lh = 1'b0; ire = 1'b0; wr = 1'b0; cs = 1'b0;
      if (kind == K_START) begin
         rg = 4'b0001;
      end else if (kind == K_FL || kind == K_FH) begin
         od = 2'b10; cs = 1'b1; ire = 1'b1; lh = (kind == K_FH); irF = 2'b01;
         rg = 4'b0001; arfF = 2'b11;
      end else if (kind == K_EX) begin
         case (w[15:12])
            4'h1: begin ma = 2'b10; rs = 4'b0001 << w[11:10]; rfF = 2'b01; end
            4'h2: begin cs = 1'b1; ma = 2'b01; rs = 4'b0001 << w[11:10]; rfF = 2'b01; end
            4'h3: begin oa = {1'b0, w[9:8]}; cs = 1'b1; wr = 1'b1; end
            4'h4: begin
               oa = {1'b0, w[9:8]}; ob = {1'b0, w[7:6]}; aluF = w[3:0];
               rs = 4'b0001 << w[11:10]; rfF = 2'b01;
            end
            4'h5: begin mb = 2'b10; rg = 4'b0010; arfF = 2'b01; end
            4'h6: if (z) begin mb = 2'b10; rg = 4'b0001; arfF = 2'b01; end
            default: ;
         endcase
      end
      return {oa, ob, rfF, rs, 4'b0000, aluF, 2'b00, od, arfF, rg, lh, ire, irF, wr, cs, ma, mb, 1'b0};
   endfunction

   task automatic refExec(input logic [15:0] w);
      logic [7:0] r;
      refPc = 8'(refPc + 8'd2);
      case (w[15:12])
         4'h1: refRf[w[11:10]] = w[7:0];
         4'h2: refRf[w[11:10]] = refMem[refAr];
         4'h3: refMem[refAr] = refRf[w[9:8]];
         4'h4: begin
            r = aluFn(w[3:0], refRf[w[9:8]], refRf[w[7:6]]);
            refRf[w[11:10]] = r;
            refZ = (r == 8'h00);
         end
         4'h5: refAr = w[7:0];
         4'h6: if (refZ) refPc = w[7:0];
         default: ;
      endcase
   endtask

   // Random image; HLT opcodes mostly suppressed so runs are long enough to wrap the PC.
   task automatic newImage(input bit directed);
      logic [15:0] dirW [15] = '{16'h1422, 16'h1807, 16'h4D81, 16'h5040, 16'h3100, 16'h2000, 16'h4142,
                                 16'h6018, 16'h1CFF, 16'h1CFF, 16'h1CFF, 16'h1CFF, 16'h4181, 16'h6000,
                                 16'hF000};
      for (int i = 0; i < 256; i++) begin
         progImg[i] = 8'($urandom);
         if ((i % 2) == 1 && progImg[i][7:4] == 4'hF && $urandom_range(0, 7) != 0) progImg[i][7:4] = 4'h0;
      end
      if (directed)
         for (int i = 0; i < 15; i++) begin
            progImg[2*i]   = dirW[i][7:0];
            progImg[2*i+1] = dirW[i][15:8];
         end
   endtask

   task automatic driveRandom();
      Start   = ($urandom_range(0, 3) == 0);
      Step    = ($urandom_range(0, 3) == 0);
      cnoJunk = 3'($urandom);
   endtask

   task automatic haltSeq();
      newImage(1'b0);
      loadImg = 1'b1;
      Start = 1'b0; Step = 1'($urandom_range(0, 1));
      #1;
      checkVal("halt_ctrl", 64'(obsCtrl), 64'(expCtrl(K_ZERO, 16'h0, 1'b0)));
      checkVal("halt_st", 64'({Busy, Halted}), 64'(2'b01));
      @(negedge Clock);
      loadImg = 1'b0;
      refMem = progImg;
      repeat ($urandom_range(1, 3)) begin
         Start = 1'b0; Step = 1'($urandom_range(0, 1));
         #1;
         checkVal("halt_hold", 64'(obsCtrl), 64'(expCtrl(K_ZERO, 16'h0, 1'b0)));
         checkVal("halt_hold_st", 64'({Busy, Halted}), 64'(2'b01));
         @(negedge Clock);
      end
      Start = 1'b1; Step = 1'($urandom_range(0, 1));
      #1;
      checkVal("restart", 64'(obsCtrl), 64'(expCtrl(K_START, 16'h0, 1'b0)));
      checkVal("restart_st", 64'({Busy, Halted}), 64'(2'b01));
      @(negedge Clock);
      Start = 1'b0;
      refPc = 8'h00;
   endtask

`ifdef ALU_SYSTEM_CTRL_STEP_EN
   task automatic stepSeq();
      repeat (5) begin
         Start = 1'($urandom_range(0, 1)); Step = 1'b0;
         #1;
         checkVal("wait_ctrl", 64'(obsCtrl), 64'(expCtrl(K_ZERO, 16'h0, 1'b0)));
         checkVal("wait_st", 64'({Busy, Halted}), 64'(2'b10));
         @(negedge Clock);
      end
      Start = 1'($urandom_range(0, 1)); Step = 1'b1;
      #1;
      checkVal("wait_go", 64'(obsCtrl), 64'(expCtrl(K_ZERO, 16'h0, 1'b0)));
      @(negedge Clock);
      Step = 1'b0;
   endtask
`endif

   task automatic runInstr();
      logic [15:0] w;
      w = {refMem[8'(refPc + 8'd1)], refMem[refPc]};
      driveRandom(); #1;
      checkVal("fetchL", 64'(obsCtrl), 64'(expCtrl(K_FL, w, refZ)));
      checkVal("fetchL_st", 64'({Busy, Halted}), 64'(2'b10));
      @(negedge Clock);
      driveRandom(); #1;
      checkVal("fetchH", 64'(obsCtrl), 64'(expCtrl(K_FH, w, refZ)));
      checkVal("fetchH_st", 64'({Busy, Halted}), 64'(2'b10));
      @(negedge Clock);
      driveRandom(); #1;
      checkVal("ir", 64'(dpIr), 64'(w));
      checkVal("exec", 64'(obsCtrl), 64'(expCtrl(K_EX, w, refZ)));
      checkVal("exec_st", 64'({Busy, Halted}), 64'(2'b10));
      @(negedge Clock);
      refExec(w);
      checkVal("arch", 64'({dpPc, dpAr, dpRf[0], dpRf[1], dpRf[2], dpRf[3], dpZ}),
                       64'({refPc, refAr, refRf[0], refRf[1], refRf[2], refRf[3], refZ}));
      if (w[15:12] == 4'h3) checkVal("mem", 64'(dpMem[refAr]), 64'(refMem[refAr]));
      if (w[15:12] == 4'hF) haltSeq();
`ifdef ALU_SYSTEM_CTRL_STEP_EN
      else stepSeq();
`endif
   endtask

   initial begin
      Reset_n = 1'b0; Start = 1'b0; Step = 1'b0; cnoJunk = 3'b000; loadImg = 1'b1;
      newImage(1'b1);
      @(negedge Clock);
      loadImg = 1'b0;
      refMem = progImg;
      #1;
      checkVal("rst_ctrl", 64'(obsCtrl), 64'(expCtrl(K_ZERO, 16'h0, 1'b0)));
      checkVal("rst_st", 64'({Busy, Halted}), 64'(2'b00));
      Reset_n = 1'b1;
      @(negedge Clock);
      repeat (2) begin
         Start = 1'b0; Step = 1'($urandom_range(0, 1));
         #1;
         checkVal("idle_ctrl", 64'(obsCtrl), 64'(expCtrl(K_ZERO, 16'h0, 1'b0)));
         checkVal("idle_st", 64'({Busy, Halted}), 64'(2'b00));
         @(negedge Clock);
      end
      Start = 1'b1; Step = 1'b1;
      #1;
      checkVal("start", 64'(obsCtrl), 64'(expCtrl(K_START, 16'h0, 1'b0)));
      @(negedge Clock);
      Start = 1'b0; Step = 1'b0;
      refPc = 8'h00;

      repeat (NUM_INSTR) runInstr();

      // Reset in the middle of a fetch, then restart from PC 0.
      Start = 1'b0;
      @(negedge Clock);
      #1 Reset_n = 1'b0;
      #1;
      checkVal("rstmid_ctrl", 64'(obsCtrl), 64'(expCtrl(K_ZERO, 16'h0, 1'b0)));
      checkVal("rstmid_st", 64'({Busy, Halted}), 64'(2'b00));
      Start = 1'b1;
      #1;
      checkVal("rstmid_start", 64'(obsCtrl), 64'(expCtrl(K_ZERO, 16'h0, 1'b0)));
      @(negedge Clock);
      Reset_n = 1'b1; Start = 1'b0;
      #1;
      checkVal("post_rst_st", 64'({Busy, Halted}), 64'(2'b00));
      @(negedge Clock);
      Start = 1'b1;
      #1;
      checkVal("restart2", 64'(obsCtrl), 64'(expCtrl(K_START, 16'h0, 1'b0)));
      @(negedge Clock);
      Start = 1'b0;
      refPc = 8'h00;
      repeat (6) runInstr();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
